// File: rtl/nchan_mux_pkg.sv
// -----------------------------------------------------------------------------
// nchan_mux_pkg
//   Shared constants for the N-channel sequenced multiplexer.
//   MODE_MANUAL / MODE_SCAN give names to the two values of the MODE input.
// -----------------------------------------------------------------------------
package nchan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;   // select changes only on SEL_LD
    localparam logic MODE_SCAN   = 1'b1;   // select advances every DWELL cycles

endpackage

// File: rtl/nchan_mux_comb.sv
// -----------------------------------------------------------------------------
// nchan_mux_comb
//   Purely combinational N_CH:1 selector of WIDTH-bit words.
//   Ports:
//     d     in   N_CH*WIDTH   packed channels, channel k = d[k*WIDTH +: WIDTH]
//     sel   in   SEL_W        channel index
//     word  out  WIDTH        selected channel (zero for an index >= N_CH)
// -----------------------------------------------------------------------------
module nchan_mux_comb #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic [N_CH*WIDTH-1:0]   d,
    input  logic [$clog2(N_CH)-1:0] sel,
    output logic [WIDTH-1:0]        word
);

    localparam int SEL_W = $clog2(N_CH);

    always_comb begin
        // NOTE: a default before the loop keeps every path assigned, so no latch.
        word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                word = d[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/nchan_mux_seq.sv
// -----------------------------------------------------------------------------
// nchan_mux_seq
//   N-channel, WIDTH-bit multiplexer with a registered output. The channel
//   select is either loaded explicitly (manual mode) or stepped through all
//   channels, spending DWELL enabled cycles on each (scan mode).
//   Ports:
//     CLK      in   1            clock, all state on the rising edge
//     RST_N    in   1            synchronous active-low reset
//     EN       in   1            output / scan enable
//     MODE     in   1            MODE_MANUAL or MODE_SCAN
//     SEL_LD   in   1            load SEL into the select register
//     SEL      in   SEL_W        requested channel
//     D        in   N_CH*WIDTH   packed channel inputs
//     Z        out  WIDTH        registered selected data
//     Z_VALID  out  1            Z was sampled on the previous EN cycle
//     CUR_SEL  out  SEL_W        current select register
//     WRAP     out  1            pulse: scan wrapped from N_CH-1 to 0
//     SEL_ERR  out  1            pulse: SEL_LD with an out-of-range SEL
// -----------------------------------------------------------------------------
module nchan_mux_seq
    import nchan_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic                    MODE,
    input  logic                    SEL_LD,
    input  logic [$clog2(N_CH)-1:0] SEL,
    input  logic [N_CH*WIDTH-1:0]   D,
    output logic [WIDTH-1:0]        Z,
    output logic                    Z_VALID,
    output logic [$clog2(N_CH)-1:0] CUR_SEL,
    output logic                    WRAP,
    output logic                    SEL_ERR
);

    localparam int SEL_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(DWELL + 1);

    // One extra bit so the range test also works when N_CH is a power of two.
    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;
    logic             mode_q;      // MODE seen at the previous edge
    logic [WIDTH-1:0] word;

    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    nchan_mux_comb #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) u_sel (
        .d    (D),
        .sel  (CUR_SEL),
        .word (word)
    );

    // Select / dwell next state. Priority: load request, then a mode switch
    // (which restarts the dwell without moving the select), then scan stepping.
    always_comb begin
        cnt_nxt  = cnt;
        sel_nxt  = CUR_SEL;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;

        if (SEL_LD) begin
            if ({1'b0, SEL} < N_CH_EXT) begin
                sel_nxt = SEL;
                cnt_nxt = '0;
            end else begin
                err_nxt = 1'b1;
            end
        end else if ((MODE != mode_q) || (MODE == MODE_MANUAL)) begin
            cnt_nxt = '0;
        end else if (EN) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                if (CUR_SEL == LAST_SEL) begin
                    sel_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    sel_nxt = CUR_SEL + 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, whatever the statement order.
        if (!RST_N) begin
            // NOTE: the reset loads every flop, including the data register, so
            // Z is a defined zero straight after reset.
            Z       <= '0;
            Z_VALID <= 1'b0;
            CUR_SEL <= '0;
            cnt     <= '0;
            WRAP    <= 1'b0;
            SEL_ERR <= 1'b0;
            // Track MODE through reset so leaving reset is not seen as a switch.
            mode_q  <= MODE;
        end else begin
            if (EN) begin
                Z <= word;
            end
            Z_VALID <= EN;
            CUR_SEL <= sel_nxt;
            cnt     <= cnt_nxt;
            WRAP    <= wrap_nxt;
            SEL_ERR <= err_nxt;
            mode_q  <= MODE;
        end
    end

endmodule
